// File: rtl/tmds_channel_encoder.sv
// rtl/tmds_channel_encoder.sv - one lane of the DVI/HDMI TMDS 8b/10b encoder
//
// Purpose: turns 8-bit pixel data (de=1) or two control bits (de=0) into
// 10-bit DC-balanced TMDS symbols, one per pixel clock, two clocks of latency.
//
// Ports:
//   clk        pixel clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   de         1 = encode data, 0 = encode {c1,c0} as a control token
//   data       8-bit pixel component
//   c0, c1     control bits (HSYNC/VSYNC on the blue lane)
//   tmds       10-bit symbol, bit 0 transmitted first (inverted when INVERT=1)
//   disparity  signed running disparity after the current output symbol
module tmds_channel_encoder #(
  parameter bit INVERT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de,
  input  logic [7:0]        data,
  input  logic              c0,
  input  logic              c1,
  output logic [9:0]        tmds,
  output logic signed [4:0] disparity
);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Stage 1: transition minimisation
  logic [3:0] n1_data;
  logic       use_xnor;
  logic [8:0] qm_d;
  logic [8:0] qm_q;
  logic       de_q;
  logic [1:0] c_q;

  always_comb begin
    n1_data  = popcount8(data);
    use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data[0]);
    qm_d     = '0;
    qm_d[0]  = data[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ data[i]) : (qm_d[i-1] ^ data[i]);
    end
    // bit 8 tells the decoder which chain was used
    qm_d[8] = ~use_xnor;
  end

  // Stage 2: DC balance
  logic [3:0]        n1q;
  logic signed [5:0] bal;      // n1q - n0q
  logic signed [5:0] cnt_ext;
  logic signed [5:0] cnt_d;
  logic [9:0]        out_d;
  logic [9:0]        out_q;
  logic signed [4:0] cnt_q;

  always_comb begin
    n1q     = popcount8(qm_q[7:0]);
    bal     = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
    cnt_ext = {cnt_q[4], cnt_q};
    out_d   = TOK_00;
    cnt_d   = '0;
    if (!de_q) begin
      // blanking always restarts the disparity count from zero
      case (c_q)
        2'b00:   out_d = TOK_00;
        2'b01:   out_d = TOK_01;
        2'b10:   out_d = TOK_10;
        default: out_d = TOK_11;
      endcase
      cnt_d = '0;
    end else if ((cnt_q == 5'sd0) || (n1q == 4'd4)) begin
      out_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_d = qm_q[8] ? (cnt_ext + bal) : (cnt_ext - bal);
    end else if ((!cnt_q[4] && (n1q > 4'd4)) || (cnt_q[4] && (n1q < 4'd4))) begin
      // word would push disparity further the same way: send it inverted
      out_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d = cnt_ext + (qm_q[8] ? 6'sd2 : 6'sd0) - bal;
    end else begin
      out_d = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_d = cnt_ext + bal - (qm_q[8] ? 6'sd0 : 6'sd2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qm_q  <= '0;
      de_q  <= 1'b0;
      c_q   <= 2'b00;
      out_q <= TOK_00;
      cnt_q <= '0;
    end else begin
      qm_q  <= qm_d;
      de_q  <= de;
      c_q   <= {c1, c0};
      out_q <= out_d;
      cnt_q <= $signed(cnt_d[4:0]);
    end
  end

  // The algorithm keeps the count within -8..+8, so 5 bits never wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((cnt_d >= -6'sd8) && (cnt_d <= 6'sd8));
    end
  end

  assign tmds      = INVERT ? ~out_q : out_q;
  assign disparity = cnt_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// tb/tb_tmds_channel_encoder.sv - self-checking bench for tmds_channel_encoder
module tb_tmds_channel_encoder;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              de = 1'b0;
  logic [7:0]        data = 8'h00;
  logic              c0 = 1'b0;
  logic              c1 = 1'b0;
  logic [9:0]        tmds0;
  logic [9:0]        tmds1;
  logic signed [4:0] disp0;
  logic signed [4:0] disp1;

  always #5 clk = ~clk;

  tmds_channel_encoder #(.INVERT(1'b0)) dut (
    .clk(clk), .rst(rst), .de(de), .data(data), .c0(c0), .c1(c1),
    .tmds(tmds0), .disparity(disp0)
  );

  tmds_channel_encoder #(.INVERT(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .de(de), .data(data), .c0(c0), .c1(c1),
    .tmds(tmds1), .disparity(disp1)
  );

  typedef struct {
    logic [9:0] sym;
    int         cnt;
    logic       de;
    logic [7:0] data;
    logic [1:0] c;
  } exp_t;

  exp_t       exp_q[$];
  int         model_cnt;
  int         errors = 0;
  int         checks = 0;
  logic [9:0] tok[4];

  // Reference: pick the word, then let disparity follow the 10-bit symbol's ones-minus-zeros.
  function automatic exp_t encode(input logic e_de, input logic [7:0] d, input logic [1:0] c);
    exp_t       e;
    int         n1;
    int         bal;
    bit         xn;
    bit         inv;
    logic [8:0] qm;
    e.de = e_de; e.data = d; e.c = c;
    if (!e_de) begin
      e.sym = tok[c];
      model_cnt = 0;
    end else begin
      n1 = $countones(d);
      xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !xn;
      bal = 2 * $countones(qm[7:0]) - 8;
      if (model_cnt == 0 || bal == 0) inv = !qm[8];
      else inv = ((model_cnt > 0) == (bal > 0));
      e.sym = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
      model_cnt += 2 * $countones(e.sym) - 10;
    end
    e.cnt = model_cnt;
    return e;
  endfunction

  function automatic logic [7:0] decode_data(input logic [9:0] s);
    logic [7:0] dd;
    logic [7:0] r;
    dd = s[9] ? ~s[7:0] : s[7:0];
    r[0] = dd[0];
    for (int i = 1; i < 8; i++) r[i] = s[8] ? (dd[i] ^ dd[i-1]) : ~(dd[i] ^ dd[i-1]);
    return r;
  endfunction

  function automatic logic [2:0] decode_ctrl(input logic [9:0] s);
    logic [2:0] r;
    r = 3'b100;  // bit 2 = not a token
    for (int j = 0; j < 4; j++) if (tok[j] == s) r = {1'b0, 2'(j)};
    return r;
  endfunction

  task automatic reset_model();
    exp_t e;
    exp_q.delete();
    model_cnt = 0;
    e.sym = tok[0]; e.cnt = 0; e.de = 1'b0; e.data = 8'h00; e.c = 2'b00;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
  endtask

  // Drives one input, clocks once, returns the expectation for the symbol now on the outputs.
  task automatic drive(input logic d_de, input logic [7:0] d_data, input logic [1:0] d_c, output exp_t e);
    de = d_de; data = d_data; {c1, c0} = d_c;
    exp_q.push_back(encode(d_de, d_data, d_c));
    @(posedge clk); #1;
    e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; de = 1'b0; {c1, c0} = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tmds0 !== 10'h354) begin errors++; $display("FAIL reset_tmds: got %h expected 354", tmds0); end
      checks++;
      if (disp0 !== 5'sd0) begin errors++; $display("FAIL reset_disp: got %0d expected 0", disp0); end
      checks++;
      if (tmds1 !== 10'h0AB) begin errors++; $display("FAIL reset_tmds_inv: got %h expected 0ab", tmds1); end
    end
    rst = 1'b0;
    reset_model();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 2'b00, e);
      checks++;
      if (tmds0 !== 10'h354) begin errors++; $display("FAIL reset_release: got %h expected 354", tmds0); end
    end
  endtask

  task automatic test_control_tokens();
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 8'($urandom), 2'(i % 4), e);
      checks++;
      if (tmds0 !== tok[e.c]) begin errors++; $display("FAIL ctrl_token: got %h expected %h", tmds0, tok[e.c]); end
      checks++;
      if (disp0 !== 5'sd0) begin errors++; $display("FAIL ctrl_disp: got %0d expected 0", disp0); end
    end
  endtask

  task automatic test_dc_balance();
    exp_t e;
    int   want_cnt[9];
    bit   hit_zero;
    want_cnt = '{-8, 2, -6, 4, -4, 6, -2, 8, 0};
    hit_zero = 0;
    apply_reset();
    drive(1'b1, 8'h00, 2'b00, e);  // reset-state token still leaving the pipe
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 8'h00, 2'b00, e);
      checks++;
      if (tmds0 !== ((k % 2 == 0) ? 10'h100 : 10'h3FF)) begin
        errors++; $display("FAIL dc_sym%0d: got %h expected %h", k, tmds0, (k % 2 == 0) ? 10'h100 : 10'h3FF);
      end
      checks++;
      if (int'(disp0) != want_cnt[k]) begin
        errors++; $display("FAIL dc_cnt%0d: got %0d expected %0d", k, disp0, want_cnt[k]);
      end
      if (disp0 == 5'sd0) hit_zero = 1;
    end
    checks++;
    if (!hit_zero) begin errors++; $display("FAIL dc_return_zero: got no zero expected zero within 10"); end
  endtask

  task automatic test_xnor_path();
    exp_t e;
    apply_reset();
    drive(1'b1, 8'hFF, 2'b00, e);
    drive(1'b0, 8'h00, 2'b00, e);
    checks++;
    if (tmds0 !== 10'h200) begin errors++; $display("FAIL xnor_sym: got %h expected 200", tmds0); end
    checks++;
    if (disp0 !== -5'sd8) begin errors++; $display("FAIL xnor_disp: got %0d expected -8", disp0); end
  endtask

  task automatic test_boundary();
    exp_t       e;
    logic [7:0] vals[4];
    vals = '{8'h10, 8'h20, 8'h30, 8'h40};
    apply_reset();
    drive(1'b1, vals[0], 2'b01, e);  // outputs reset token
    for (int k = 1; k < 7; k++) begin
      if (k < 4) drive(1'b1, vals[k], 2'b01, e);
      else drive(1'b0, 8'h00, 2'b01, e);
      checks++;
      if (tmds0 !== e.sym) begin errors++; $display("FAIL bnd_sym%0d: got %h expected %h", k, tmds0, e.sym); end
      checks++;
      if (tmds1 !== ~e.sym) begin errors++; $display("FAIL bnd_inv%0d: got %h expected %h", k, tmds1, ~e.sym); end
      checks++;
      if (e.de && (decode_data(tmds0) !== vals[k-1])) begin
        errors++; $display("FAIL bnd_dec%0d: got %h expected %h", k, decode_data(tmds0), vals[k-1]);
      end
      if (k >= 5) begin
        checks++;
        if (tmds0 !== 10'h0AB) begin errors++; $display("FAIL bnd_ctrl%0d: got %h expected 0ab", k, tmds0); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      drive(1'(i % 2), 8'($urandom), 2'($urandom), e);
      checks++;
      if (tmds0 !== e.sym) begin errors++; $display("FAIL b2b_sym: got %h expected %h", tmds0, e.sym); end
      checks++;
      if (int'(disp0) != e.cnt) begin errors++; $display("FAIL b2b_disp: got %0d expected %0d", disp0, e.cnt); end
    end
  endtask

  task automatic test_midstream_reset();
    exp_t e;
    for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom), 2'b00, e);
    de = 1'b1; data = 8'hA5; rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tmds0 !== 10'h354) begin errors++; $display("FAIL mid_rst_tmds: got %h expected 354", tmds0); end
    checks++;
    if (disp0 !== 5'sd0) begin errors++; $display("FAIL mid_rst_disp: got %0d expected 0", disp0); end
    rst = 1'b0;
    reset_model();
    drive(1'b1, 8'h00, 2'b00, e);
    checks++;
    if (tmds0 !== 10'h354) begin errors++; $display("FAIL mid_first: got %h expected 354", tmds0); end
    drive(1'b1, 8'h00, 2'b00, e);
    checks++;
    if (tmds0 !== 10'h100 || disp0 !== -5'sd8) begin
      errors++; $display("FAIL mid_data: got %h/%0d expected 100/-8", tmds0, disp0);
    end
  endtask

  task automatic test_random();
    exp_t       e;
    logic [2:0] dc;
    apply_reset();
    for (int i = 0; i < 20000; i++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom), e);
      checks++;
      if (tmds0 !== e.sym) begin errors++; $display("FAIL rnd_sym @%0d: got %h expected %h", i, tmds0, e.sym); end
      checks++;
      if (int'(disp0) != e.cnt) begin errors++; $display("FAIL rnd_disp @%0d: got %0d expected %0d", i, disp0, e.cnt); end
      checks++;
      if (tmds1 !== ~e.sym || disp1 !== disp0) begin
        errors++; $display("FAIL rnd_inv @%0d: got %h/%0d expected %h/%0d", i, tmds1, disp1, ~e.sym, e.cnt);
      end
      checks++;
      if (int'(disp0) < -8 || int'(disp0) > 8) begin
        errors++; $display("FAIL rnd_range @%0d: got %0d expected -8..8", i, disp0);
      end
      checks++;
      dc = decode_ctrl(tmds0);
      if (e.de) begin
        if (decode_data(tmds0) !== e.data) begin
          errors++; $display("FAIL rnd_dec_data @%0d: got %h expected %h", i, decode_data(tmds0), e.data);
        end
      end else if (dc !== {1'b0, e.c}) begin
        errors++; $display("FAIL rnd_dec_ctrl @%0d: got %b expected 0%b", i, dc, e.c);
      end
    end
  endtask

  initial begin
    tok[0] = 10'h354; tok[1] = 10'h0AB; tok[2] = 10'h154; tok[3] = 10'h2AB;
    test_reset();
    test_control_tokens();
    test_dc_balance();
    test_xnor_path();
    test_boundary();
    test_back_to_back();
    test_midstream_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
